// File: rtl/pulse_width_decoder.sv
// Measures the high time of each pulse on `in` in clk cycles and reports the width with a one-cycle strobe.
// Optional build macro PWD_SYNC_EN adds a two-flop input synchronizer for an asynchronous `in`.
module pulse_width_decoder #(
   parameter int WIDTH   = 8,
   parameter int EXP_LEN = 4,
   parameter int TOL     = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in,
   output logic             valid,
   output logic [WIDTH-1:0] width,
   output logic             match,
   output logic             ovf,
   output logic             busy
);

   typedef enum logic {
      IDLE = 1'b0,
      MEAS = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
   localparam logic [WIDTH:0]   EXP_W   = (WIDTH+1)'(EXP_LEN);
   localparam logic [WIDTH:0]   TOL_W   = (WIDTH+1)'(TOL);

   logic in_s;
   logic in_dly_q;
   logic rise;

`ifdef PWD_SYNC_EN
   logic sync1_q;
   logic sync2_q;

   // Synchronizer resets high so a line already high at reset release is not a pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= in;
         sync2_q <= sync1_q;
      end
   end

   assign in_s = sync2_q;
`else
   assign in_s = in;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_dly_q <= 1'b1;
      end else begin
         in_dly_q <= in_s;
      end
   end

   assign rise = in_s & ~in_dly_q;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             flag_q, flag_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] width_q, width_d;
   logic             match_q, match_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH:0]   cnt_ext;
   logic             lo_ok;
   logic             hi_ok;

   // Tolerance window evaluated one bit wider than the counter.
   assign cnt_ext = {1'b0, cnt_q};
   assign lo_ok   = (cnt_ext + TOL_W) >= EXP_W;
   assign hi_ok   = cnt_ext <= (EXP_W + TOL_W);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
         valid_q <= 1'b0;
         width_q <= '0;
         match_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
         valid_q <= valid_d;
         width_q <= width_d;
         match_q <= match_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flag_d  = flag_q;
      valid_d = 1'b0;
      width_d = width_q;
      match_d = match_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            if (rise) begin
               cnt_d   = CNT_ONE;
               flag_d  = (CNT_ONE == CNT_MAX);
               state_d = MEAS;
            end
         end
         MEAS: begin
            if (in_s) begin
               // Saturate; the flag marks that the full-scale count was reached.
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_ONE;
                  if (cnt_q == (CNT_MAX - CNT_ONE)) begin
                     flag_d = 1'b1;
                  end
               end
            end else begin
               valid_d = 1'b1;
               width_d = cnt_q;
               ovf_d   = flag_q;
               match_d = lo_ok && hi_ok && !flag_q;
               flag_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign valid = valid_q;
   assign width = width_q;
   assign match = match_q;
   assign ovf   = ovf_q;
   assign busy  = (state_q == MEAS);

endmodule
